// File: rtl/spart_pkg.sv
// Shared types for the parametrised SPART receiver: FSM states, parity modes,
// the FIFO word layout and the majority-vote helper.
package spart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest supported frame; narrower builds zero-extend into this field.
  localparam int MAX_DATA_BITS = 9;

  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_word_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_rx_fifo.sv
// Generic first-word-fall-through FIFO; the head is presented combinationally
// and reads as zero while empty.
module spart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spart_rx_fifo_param.sv
// Oversampled async-serial receiver feeding an FWFT word FIFO with sticky overrun.
// Define SPART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module spart_rx_fifo_param
  import spart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 rd,
  input  logic                 clr_ovr,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rda,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE + 1);
`ifdef SPART_RX_MAJORITY_EN
  localparam int MAJ_OFF = 1;
`else
  localparam int MAJ_OFF = 0;
`endif
  // Decisions land MAJ_OFF ticks after the true mid-point; data bits then
  // follow every OVERSAMPLE ticks from that decision.
  localparam logic [CNT_W-1:0] START_DEC = CNT_W'(OVERSAMPLE / 2 + MAJ_OFF - 1);
  localparam logic [CNT_W-1:0] BIT_DEC   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  logic                 rx_meta;
  logic                 rxs;
  logic                 rx_last;
  logic                 bit_val;
  rx_state_t            state;
  rx_state_t            state_nxt;
  logic [CNT_W-1:0]     tick_cnt;
  logic [3:0]           bit_cnt;
  logic                 at_dec;
  logic                 push;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_acc;
  logic                 par_err_r;
  rx_word_t             push_word;
  rx_word_t             head;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 unused_head_data;

`ifdef SPART_RX_MAJORITY_EN
  logic [1:0] rx_hist;
  assign rx_last = rx_hist[0];
  assign bit_val = maj3(rx_hist[1], rx_hist[0], rxs);
`else
  logic rx_hist;
  assign rx_last = rx_hist;
  assign bit_val = rxs;
`endif

  always_comb begin
    state_nxt = state;
    at_dec    = 1'b0;
    push      = 1'b0;
    if (enable) begin
      case (state)
        IDLE: if (!rxs && rx_last) state_nxt = START;
        START: begin
          at_dec = (tick_cnt == START_DEC);
          if (at_dec) state_nxt = bit_val ? IDLE : DATA;
        end
        DATA: begin
          at_dec = (tick_cnt == BIT_DEC);
          if (at_dec && bit_cnt == LAST_DATA)
            state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
        end
        PARITY: begin
          at_dec = (tick_cnt == BIT_DEC);
          if (at_dec) state_nxt = STOP;
        end
        STOP: begin
          at_dec = (tick_cnt == BIT_DEC);
          if (at_dec && bit_cnt == LAST_STOP) begin
            state_nxt = IDLE;
            push      = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Stage p0: synchroniser, sample history, FSM and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_hist  <= '1;
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      if (enable) begin
        rx_hist <= $bits(rx_hist)'({rx_hist, rxs});
        state   <= state_nxt;
        if (state_nxt != state || at_dec || state == IDLE) tick_cnt <= '0;
        else                                                tick_cnt <= tick_cnt + CNT_W'(1);
        if (state_nxt != state) bit_cnt <= '0;
        else if (at_dec)        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

  // Stage p1: word assembly; fully rewritten each frame so no reset needed
  always_ff @(posedge clk) begin
    if (at_dec) begin
      case (state)
        START: begin
          frame_acc <= 1'b0;
          par_err_r <= 1'b0;
        end
        DATA:    shreg     <= {bit_val, shreg[DATA_BITS-1:1]};
        PARITY:  par_err_r <= ((^shreg) ^ bit_val) != (PARITY_MODE == PAR_ODD);
        STOP:    frame_acc <= frame_acc | ~bit_val;
        default: ;
      endcase
    end
  end

  assign push_word.frame_err  = frame_acc | ~bit_val;
  assign push_word.parity_err = par_err_r;
  assign push_word.data       = MAX_DATA_BITS'(shreg);

  spart_rx_fifo #(
    .WIDTH($bits(rx_word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (rd),
    .din  (push_word),
    .dout (head),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst)                                 overrun <= 1'b0;
    else if (push && fifo_full && !(rd && rda)) overrun <= 1'b1;
    else if (clr_ovr)                        overrun <= 1'b0;
  end

  assign unused_head_data = ^head.data;
  assign data       = head.data[DATA_BITS-1:0];
  assign frame_err  = head.frame_err;
  assign parity_err = head.parity_err;
  assign rda        = !fifo_empty;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spart_rx_fifo_param.sv
// Directed bench for spart_rx_fifo_param: a no-parity/1-stop instance and an
// even-parity/2-stop instance, checked against a queue of expected words.
module tb_spart_rx_fifo_param;

  localparam int OS = 16;
`ifdef SPART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic       clk = 1'b0;
  logic       enable = 1'b0;
  logic       en_hold;
  logic       rst;
  logic       line;
  logic       sel;
  logic       rxd_a, rxd_b;
  logic       rd_a, rd_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic       fe_a, pe_a, rda_a, ovr_a, busy_a;
  logic       fe_b, pe_b, rda_b, ovr_b, busy_b;

  logic [9:0] exp_q[$];
  logic       model_ovr;
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;
  always @(negedge clk) enable <= en_hold ? 1'b0 : ~enable;

  assign rxd_a = sel ? 1'b1 : line;
  assign rxd_b = sel ? line : 1'b1;

  spart_rx_fifo_param dut_a (
    .clk(clk), .rst(rst), .enable(enable), .rxd(rxd_a), .rd(rd_a), .clr_ovr(clr_a),
    .data(data_a), .frame_err(fe_a), .parity_err(pe_a), .rda(rda_a),
    .overrun(ovr_a), .busy(busy_a)
  );

  spart_rx_fifo_param #(.PARITY_MODE(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .rxd(rxd_b), .rd(rd_b), .clr_ovr(clr_b),
    .data(data_b), .frame_err(fe_b), .parity_err(pe_b), .rda(rda_b),
    .overrun(ovr_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next clock edge that carries an enable tick.
  task automatic tick();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!enable && n < 50);
    if (!enable) begin
      $display("FAIL tick_timeout: enable observed %0b expected 1", enable);
      $fatal(1, "enable tick never arrived");
    end
    #1;
  endtask

  task automatic idle_ticks(input int n);
    line = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one frame tick by tick; tgt selects dut_b (even parity, 2 stops).
  task automatic send(input logic [7:0] d, input bit tgt, input bit pbit,
                      input logic [1:0] stops, input int glitch,
                      input bit lat, input bit rd_push);
    logic [15:0] bits;
    logic [7:0]  d_exp;
    int          n, nst, dec;
    bit          pe, fe;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n  = 9;
    pe = 1'b0;
    if (tgt) begin
      bits[9] = pbit;
      n  = 10;
      pe = (^d) ^ pbit;
    end
    nst = tgt ? 2 : 1;
    for (int s = 0; s < nst; s++) bits[n+s] = stops[s];
    n  = n + nst;
    fe = tgt ? !(&stops) : !stops[0];
    d_exp = d;
    if (glitch >= 0 && MAJ == 0) d_exp[glitch/OS - 1] = ~d_exp[glitch/OS - 1];
    // Two synchroniser ticks plus the start mid-point, then whole bit periods.
    dec = 2 + OS/2 + MAJ + OS*(n-1);
    sel = tgt;
    tick();
    for (int t = 0; t < n*OS; t++) begin
      line = bits[t/OS] ^ (t == glitch);
      tick();
      if (lat && t + 1 == dec - 1) check("lat_before_push_rda", rda_a, 0);
      if (lat && t + 1 == dec)     check("lat_after_push_rda", rda_a, 1);
      if (rd_push && t + 1 == dec - 1) begin
        check("full_pushpop_head", data_a, exp_q[0][7:0]);
        @(posedge clk);
        #1 rd_a = 1'b1;
      end
      if (rd_push && t + 1 == dec) begin
        rd_a = 1'b0;
        void'(exp_q.pop_front());
      end
    end
    if (exp_q.size() < 4) exp_q.push_back({fe, pe, d_exp});
    else                  model_ovr = 1'b1;
    idle_ticks(4);
  endtask

  task automatic pop_check(input bit tgt, input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_rda"},  tgt ? rda_b  : rda_a,  1);
    check({tag, "_data"}, tgt ? data_b : data_a, e[7:0]);
    check({tag, "_ferr"}, tgt ? fe_b   : fe_a,   e[9]);
    check({tag, "_perr"}, tgt ? pe_b   : pe_a,   e[8]);
    if (tgt) rd_b = 1'b1;
    else     rd_a = 1'b1;
    @(posedge clk);
    #1;
    rd_a = 1'b0;
    rd_b = 1'b0;
  endtask

  initial begin
    line = 1'b1; sel = 1'b0; en_hold = 1'b0; model_ovr = 1'b0;
    rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rda",     rda_a,  0);
    check("reset_data",    data_a, 0);
    check("reset_ferr",    fe_a,   0);
    check("reset_perr",    pe_a,   0);
    check("reset_overrun", ovr_a,  0);
    check("reset_busy",    busy_a, 0);
    check("reset_rda_b",   rda_b,  0);
    idle_ticks(4);

    send(8'hA5, 0, 0, 2'b11, -1, 1, 0);
    check("a5_busy_idle", busy_a, 0);
    pop_check(0, "a5");
    check("a5_empty_after_pop", rda_a, 0);
    rd_a = 1'b1;
    @(posedge clk);
    #1 rd_a = 1'b0;
    check("rd_on_empty_rda", rda_a, 0);
    check("rd_on_empty_ovr", ovr_a, 0);

    tick();
    line = 1'b0;
    repeat (4) tick();
    line = 1'b1;
    repeat (4) tick();
    check("false_start_busy_mid", busy_a, 1);
    repeat (30) tick();
    check("false_start_busy", busy_a, 0);
    check("false_start_rda",  rda_a,  0);

    send(8'h55, 0, 0, 2'b00, -1, 0, 0);
    send(8'h11, 0, 0, 2'b11, -1, 0, 0);
    pop_check(0, "stoplow_55");
    pop_check(0, "after_ferr_11");

    send(8'h03, 1, 1, 2'b11, -1, 0, 0);
    send(8'h03, 1, 0, 2'b11, -1, 0, 0);
    send(8'h5A, 1, 0, 2'b01, -1, 0, 0);
    pop_check(1, "even_03_p1");
    pop_check(1, "even_03_p0");
    pop_check(1, "stop2_low_5a");
    check("b_empty", rda_b, 0);
    sel = 1'b0;

    send(8'h00, 0, 0, 2'b11, 72, 0, 0);
    pop_check(0, "glitch_bit3");

    for (int i = 1; i <= 4; i++) send(8'(i), 0, 0, 2'b11, -1, 0, 0);
    check("fill4_overrun", ovr_a, 0);
    send(8'h05, 0, 0, 2'b11, -1, 0, 1);
    check("full_pushpop_overrun", ovr_a, model_ovr);
    send(8'h06, 0, 0, 2'b11, -1, 0, 0);
    check("drop_overrun", ovr_a, model_ovr);
    en_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pop_check(0, "drain");
    check("drain_rda",        rda_a, 0);
    check("drain_overrun_sticky", ovr_a, 1);
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    check("clr_overrun", ovr_a, 0);
    en_hold = 1'b0;
    model_ovr = 1'b0;

    tick();
    line = 1'b0;
    repeat (40) tick();
    check("midframe_busy", busy_a, 1);
    line = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midframe_rst_busy", busy_a, 0);
    check("midframe_rst_rda",  rda_a,  0);
    idle_ticks(30);
    check("midframe_rst_nopush", rda_a, 0);
    send(8'h3C, 0, 0, 2'b11, -1, 0, 0);
    pop_check(0, "after_rst_3c");
    check("b_overrun_end", ovr_b, 0);
    check("b_busy_end", busy_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
